// File: rtl/l1_refill_ctrl_if.sv
// Bundle of all L1 refill handshake signals: miss input, L2 request/response, data RAM, tag RAM and completion.
// The master modport is the refill controller's view. The slave modport is the surrounding L1/L2 logic.
interface l1_refill_ctrl_if #(
    parameter int BLOCK_SIZE    = 32,
    parameter int INDEX_WIDTH   = 7,
    parameter int L2_CMND_WIDTH = 2,
    parameter int L2_SIZE_WIDTH = 3,
    parameter int L2_ADDR_WIDTH = 16,
    parameter int L2_DATA_WIDTH = 32
);
    localparam int OFF_W  = $clog2(BLOCK_SIZE);
    localparam int BEATS  = BLOCK_SIZE * 8 / L2_DATA_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TAG_W  = L2_ADDR_WIDTH - INDEX_WIDTH - OFF_W;

    logic                          miss_val;
    logic [L2_ADDR_WIDTH-1:0]      miss_addr;
    logic                          miss_rdy;
    logic                          req_val;
    logic [L2_CMND_WIDTH-1:0]      req_cmd;
    logic [L2_SIZE_WIDTH-1:0]      req_size;
    logic [L2_ADDR_WIDTH-1:0]      req_addr;
    logic                          resp_val;
    logic                          resp_err;
    logic                          resp_rdata_val;
    logic [L2_DATA_WIDTH-1:0]      resp_rdata;
    logic                          ram_wen;
    logic [INDEX_WIDTH+BEAT_W-1:0] ram_waddr;
    logic [L2_DATA_WIDTH-1:0]      ram_wdata;
    logic                          tag_wr_val;
    logic [INDEX_WIDTH-1:0]        tag_wr_addr;
    logic [TAG_W:0]                tag_wr_data;
    logic                          refill_done;
    logic                          refill_err;

    modport master (
        input  miss_val, miss_addr, resp_val, resp_err, resp_rdata_val, resp_rdata,
        output miss_rdy, req_val, req_cmd, req_size, req_addr,
               ram_wen, ram_waddr, ram_wdata, tag_wr_val, tag_wr_addr, tag_wr_data,
               refill_done, refill_err
    );

    modport slave (
        output miss_val, miss_addr, resp_val, resp_err, resp_rdata_val, resp_rdata,
        input  miss_rdy, req_val, req_cmd, req_size, req_addr,
               ram_wen, ram_waddr, ram_wdata, tag_wr_val, tag_wr_addr, tag_wr_data,
               refill_done, refill_err
    );
endinterface

// File: rtl/l1_refill_ctrl.sv
// L1 line refill sequencer: one L2 burst per miss, beats written into the data RAM, then the tag entry, then done/err.
// Optional watchdog: define L1_REFILL_TIMEOUT_EN to abort a stalled refill after TIMEOUT_CYCLES silent cycles.
module l1_refill_ctrl #(
    parameter int BLOCK_SIZE     = 32,
    parameter int INDEX_WIDTH    = 7,
    parameter int L2_CMND_WIDTH  = 2,
    parameter int L2_SIZE_WIDTH  = 3,
    parameter int L2_ADDR_WIDTH  = 16,
    parameter int L2_DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic             clk,
    input logic             rst_n,
    l1_refill_ctrl_if.master bus
);
    localparam int OFF_W  = $clog2(BLOCK_SIZE);
    localparam int BEATS  = BLOCK_SIZE * 8 / L2_DATA_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TAG_W  = L2_ADDR_WIDTH - INDEX_WIDTH - OFF_W;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_TAG  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]               state_q, state_d;
    logic [L2_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic                     err_q, err_d;
    logic                     last_beat;
    logic                     wd_expire;

    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

`ifdef L1_REFILL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q, wd_d;

    // Counts silent cycles while waiting on L2; any header or beat restarts the count.
    always_comb begin
        wd_d      = '0;
        wd_expire = 1'b0;
        if ((state_q == S_REQ) || (state_q == S_DATA)) begin
            if (bus.resp_val || bus.resp_rdata_val) begin
                wd_d = '0;
            end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                wd_expire = 1'b1;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.miss_val) begin
                    addr_d  = {bus.miss_addr[L2_ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // Beats cannot arrive before the header, so resp_rdata_val is not looked at here.
                if (bus.resp_val) begin
                    err_d   = bus.resp_err;
                    state_d = bus.resp_err ? S_DONE : S_DATA;
                end else if (wd_expire) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DATA: begin
                if (bus.resp_rdata_val) begin
                    beat_d = last_beat ? '0 : beat_q + BEAT_W'(1);
                    if (last_beat) begin
                        state_d = S_TAG;
                    end
                end else if (wd_expire) begin
                    beat_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_TAG:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    assign bus.miss_rdy    = (state_q == S_IDLE);
    assign bus.req_val     = (state_q == S_REQ);
    assign bus.req_cmd     = '0;
    assign bus.req_size    = L2_SIZE_WIDTH'(OFF_W);
    assign bus.req_addr    = addr_q;
    assign bus.ram_wen     = (state_q == S_DATA) && bus.resp_rdata_val;
    assign bus.ram_waddr   = {addr_q[OFF_W +: INDEX_WIDTH], beat_q};
    assign bus.ram_wdata   = bus.resp_rdata;
    assign bus.tag_wr_val  = (state_q == S_TAG);
    assign bus.tag_wr_addr = addr_q[OFF_W +: INDEX_WIDTH];
    assign bus.tag_wr_data = {1'b1, addr_q[L2_ADDR_WIDTH-1 -: TAG_W]};
    assign bus.refill_done = (state_q == S_DONE);
    assign bus.refill_err  = (state_q == S_DONE) && err_q;
endmodule
